// File: rtl/down_counter_pkg.sv
// Shared counter definitions: FSM state encoding and default datapath width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package down_counter_pkg;

    // Default count width, common to the up and down counters.
    localparam int DEFAULT_WIDTH = 4;

    // Timer FSM state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage : down_counter_pkg

// File: rtl/down_counter.sv
// Loadable countdown timer with one-shot and auto-reload modes.
// Latency: every output is registered; a load is visible one edge after it is sampled.
// Backpressure: enable low pauses the run and holds the count; there is no output handshake.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             terminal
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q,    state_d;
    logic [WIDTH-1:0] count_q,    count_d;
    logic [WIDTH-1:0] reload_q,   reload_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             terminal_q, terminal_d;

    // Next-state and next-count: load beats stop, stop beats decrement.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        reload_d   = reload_q;
        terminal_d = 1'b0;

        if (load) begin
            if (load_value != ZERO) begin
                // Starting (or restarting) a run never produces a terminal pulse.
                count_d  = load_value;
                reload_d = load_value;
                state_d  = ST_RUN;
            end else begin
                // A zero load is an immediate completion.
                count_d    = ZERO;
                state_d    = ST_DONE;
                terminal_d = 1'b1;
            end
        end else if (stop) begin
            // Abort: count is left where it was so software can read it.
            state_d = ST_IDLE;
        end else if (state_q == ST_RUN && enable) begin
            if (count_q > ONE) begin
                count_d = count_q - ONE;
            end else begin
                // Zero-crossing: count_q is 1 here (0 cannot occur in RUN).
                terminal_d = 1'b1;
                if (auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = ZERO;
                    state_d = ST_DONE;
                end
            end
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // All state registers; synchronous reset overrides every input.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= ZERO;
            reload_q   <= ZERO;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            terminal_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            terminal_q <= terminal_d;
        end
    end

    assign count    = count_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign terminal = terminal_q;

endmodule : down_counter
